bsg_wormhole_output_sched: RTL and testbench



---
 rtl/bsg_wormhole_output_sched.sv | 110 +++++++++++
 tb/tb_bsg_wormhole_output_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_output_sched.sv
// Per-output-port wormhole scheduler: round-robin pick of a header, then the
// output stays locked to that input until its last payload flit has transferred.
module bsg_wormhole_output_sched #(
    parameter int inputs_p     = 5,
    parameter int len_width_p  = 4,
    parameter int lg_inputs_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [inputs_p-1:0]             v_i,
    input  logic [inputs_p*len_width_p-1:0] len_i,
    input  logic                            ready_and_i,
    output logic                            v_o,
    output logic [inputs_p-1:0]             sel_o,
    output logic [lg_inputs_lp-1:0]         sel_id_o,
    output logic [inputs_p-1:0]             yumi_o,
    output logic                            busy_o
);
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_q, state_d;
    logic [lg_inputs_lp-1:0] lk_q, lk_d, last_q, last_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic [lg_inputs_lp-1:0] win, idx;
    logic                    found, transfer;
    logic [len_width_p-1:0]  len_arr [inputs_p];

    for (genvar g = 0; g < inputs_p; g++) begin : g_len
        assign len_arr[g] = len_i[g*len_width_p +: len_width_p];
    end

    // Rotating search: candidate i is checked in order starting just past last_q.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < inputs_p; i++) begin
            idx = lg_inputs_lp'((int'(last_q) + 1 + i) % inputs_p);
            if (!found && v_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        v_o      = 1'b0;
        sel_id_o = '0;
        sel_o    = '0;
        busy_o   = 1'b0;
        if (!reset_i) begin
            if (state_q == LOCKED) begin
                v_o      = v_i[lk_q];
                sel_id_o = lk_q;
                sel_o    = inputs_p'(1) << lk_q;
                busy_o   = 1'b1;
            end else if (found) begin
                v_o      = 1'b1;
                sel_id_o = win;
                sel_o    = inputs_p'(1) << win;
            end
        end
    end

    assign transfer = v_o & ready_and_i;
    assign yumi_o   = sel_o & {inputs_p{transfer}};

    always_comb begin
        state_d = state_q;
        lk_d    = lk_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (transfer) begin
                last_d = win;
                // A zero-length header is a whole packet; no lock needed.
                if (len_arr[win] != '0) begin
                    state_d = LOCKED;
                    lk_d    = win;
                    cnt_d   = len_arr[win];
                end
            end
            LOCKED: if (transfer) begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == len_width_p'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            lk_q    <= '0;
            cnt_q   <= '0;
            last_q  <= lg_inputs_lp'(inputs_p - 1);
        end else begin
            state_q <= state_d;
            lk_q    <= lk_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

`ifndef SYNTHESIS
    a_sel_onehot: assert property (@(posedge clk_i) $onehot0(sel_o));
    a_yumi_sub:   assert property (@(posedge clk_i) (yumi_o & ~sel_o) == '0);
    a_v_sel:      assert property (@(posedge clk_i) !(v_o && sel_o == '0));
`endif
endmodule

// File: tb/tb_bsg_wormhole_output_sched.sv
// Scoreboarded bench for bsg_wormhole_output_sched: directed packet scenarios
// plus a long random run against a behavioural reference model.
module tb_bsg_wormhole_output_sched;
    localparam int N = 5;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [4:0]  v_i = '0;
    logic [19:0] len_i = '0;
    logic        rdy = 1'b0;
    logic        v_o, busy_o;
    logic [4:0]  sel_o, yumi_o;
    logic [2:0]  sel_id_o;

    int checks = 0;
    int failures = 0;
    logic [14:0] sbq[$];
    logic [14:0] obs, ex;
    assign obs = {v_o, sel_o, sel_id_o, yumi_o, busy_o};

    // model state for the random run
    logic       m_lock;
    logic [2:0] m_lk, m_last;
    logic [3:0] m_cnt;

    bsg_wormhole_output_sched #(.inputs_p(5), .len_width_p(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .len_i(len_i),
        .ready_and_i(rdy), .v_o(v_o), .sel_o(sel_o), .sel_id_o(sel_id_o),
        .yumi_o(yumi_o), .busy_o(busy_o));

    always #5 clk = ~clk;

    function automatic logic [14:0] pk(logic v, logic [4:0] s, logic [2:0] id, logic [4:0] y, logic b);
        return {v, s, id, y, b};
    endfunction
    function automatic logic [4:0] oh(int i);
        return 5'(1) << i;
    endfunction
    function automatic logic [19:0] lenv(int i, int l);
        return 20'(l) << (4 * i);
    endfunction
    function automatic logic [3:0] len_of(logic [19:0] l, logic [2:0] i);
        return 4'(l >> (4 * i));
    endfunction

    task automatic drive(input logic rs, input logic [4:0] v, input logic [19:0] l, input logic r);
        @(posedge clk); #1;
        reset_i = rs; v_i = v; len_i = l; rdy = r;
    endtask

    task automatic do_reset();
        drive(1'b1, 5'b0, 20'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'b11111, lenv(0, 3), 1'b1);
        sbq.push_back(pk(0, 0, 0, 0, 0));
        @(negedge clk); ex = sbq.pop_front(); checks++;
        if (obs !== ex) begin failures++; $display("FAIL reset_hold got=%b exp=%b", obs, ex); end
        drive(1'b0, 5'b0, 20'b0, 1'b1);
        sbq.push_back(pk(0, 0, 0, 0, 0));
        @(negedge clk); ex = sbq.pop_front(); checks++;
        if (obs !== ex) begin failures++; $display("FAIL reset_idle got=%b exp=%b", obs, ex); end
    endtask

    task automatic test_single_packet();
        logic [4:0]  tv[5] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00011};
        logic        tr[5] = '{1, 1, 1, 1, 0};
        logic [14:0] te[5];
        te = '{pk(1, 5'b00001, 0, 5'b00001, 0), pk(1, 5'b00001, 0, 5'b00001, 1),
               pk(1, 5'b00001, 0, 5'b00001, 1), pk(1, 5'b00001, 0, 5'b00001, 1),
               pk(1, 5'b00010, 1, 5'b00000, 0)};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, tv[c], lenv(0, 3), tr[c]);
            sbq.push_back(te[c]);
            @(negedge clk); ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin failures++; $display("FAIL single_packet cyc=%0d got=%b exp=%b", c, obs, ex); end
        end
    endtask

    task automatic test_rotation();
        int gc[5] = '{0, 0, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 100; k++) begin
            drive(1'b0, 5'b11111, 20'b0, 1'b1);
            sbq.push_back(pk(1, oh(k % N), 3'(k % N), oh(k % N), 0));
            @(negedge clk); ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin failures++; $display("FAIL rotation cyc=%0d got=%b exp=%b", k, obs, ex); end
            for (int j = 0; j < N; j++) if (yumi_o[j]) gc[j]++;
        end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (gc[j] != 20) begin failures++; $display("FAIL rotation_share in=%0d got=%0d exp=20", j, gc[j]); end
        end
    endtask

    task automatic test_bubble();
        logic [4:0]  tv[7] = '{5'b00100, 5'b00010, 5'b00010, 5'b00010, 5'b00110, 5'b00110, 5'b00010};
        logic [14:0] te[7];
        te = '{pk(1, 5'b00100, 2, 5'b00100, 0), pk(0, 5'b00100, 2, 0, 1), pk(0, 5'b00100, 2, 0, 1),
               pk(0, 5'b00100, 2, 0, 1), pk(1, 5'b00100, 2, 5'b00100, 1),
               pk(1, 5'b00100, 2, 5'b00100, 1), pk(1, 5'b00010, 1, 5'b00010, 0)};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, tv[c], (c == 0) ? lenv(2, 2) : 20'b0, 1'b1);
            sbq.push_back(te[c]);
            @(negedge clk); ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin failures++; $display("FAIL bubble cyc=%0d got=%b exp=%b", c, obs, ex); end
        end
    endtask

    task automatic test_max_len_toggle();
        int xfers = 0;
        logic r;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            r = (k == 31) || (k % 2 == 0);
            drive(1'b0, 5'b10000, (k == 31) ? 20'b0 : lenv(4, 15), r);
            sbq.push_back(pk(1, 5'b10000, 4, r ? 5'b10000 : 5'b0, (k > 0 && k < 31)));
            @(negedge clk); ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin failures++; $display("FAIL max_len cyc=%0d got=%b exp=%b", k, obs, ex); end
            if (k < 31 && yumi_o[4]) xfers++;
        end
        checks++;
        if (xfers != 16) begin failures++; $display("FAIL max_len_xfers got=%0d exp=16", xfers); end
    endtask

    task automatic test_reset_mid_packet();
        logic        trs[5] = '{0, 0, 0, 1, 0};
        logic [4:0]  tv[5]  = '{5'b01000, 5'b01000, 5'b01000, 5'b01001, 5'b01001};
        logic        tr[5]  = '{1, 1, 1, 1, 0};
        logic [14:0] te[5];
        te = '{pk(1, 5'b01000, 3, 5'b01000, 0), pk(1, 5'b01000, 3, 5'b01000, 1),
               pk(1, 5'b01000, 3, 5'b01000, 1), pk(0, 0, 0, 0, 0), pk(1, 5'b00001, 0, 0, 0)};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(trs[c], tv[c], lenv(3, 6), tr[c]);
            sbq.push_back(te[c]);
            @(negedge clk); ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin failures++; $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, obs, ex); end
        end
    endtask

    // Expected outputs for the current inputs, then advance the model across the edge.
    task automatic model_step(output logic [14:0] e, output logic [4:0] ey);
        logic v, x; logic [4:0] s; logic [2:0] id; logic [2:0] c;
        v = 0; s = 0; id = 0;
        if (m_lock) begin
            id = m_lk; s = oh(m_lk); v = v_i[m_lk];
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = 3'((m_last + k) % N);
                if (!v && v_i[c]) begin v = 1; id = c; s = oh(c); end
            end
        end
        x  = v & rdy;
        ey = x ? s : 5'b0;
        e  = {v, s, id, ey, m_lock};
        if (x) begin
            if (m_lock) begin
                if (m_cnt == 4'd1) m_lock = 0;
                m_cnt = m_cnt - 4'd1;
            end else begin
                m_last = id;
                if (len_of(len_i, id) != 0) begin m_lock = 1; m_lk = id; m_cnt = len_of(len_i, id); end
            end
        end
    endtask

    task automatic test_random();
        int mc[5] = '{0, 0, 0, 0, 0};
        int dc[5] = '{0, 0, 0, 0, 0};
        int wt[5] = '{0, 0, 0, 0, 0};
        int maxw = 0, ilv = 0, rem = 0, src = 0, j;
        logic [4:0] v, ey;
        logic [19:0] l;
        do_reset();
        m_lock = 0; m_lk = 0; m_last = 3'd4; m_cnt = 0;
        for (int k = 0; k < 10000; k++) begin
            for (int b = 0; b < N; b++) v[b] = ($urandom_range(0, 9) < 6);
            for (int b = 0; b < N; b++) l[4*b +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            drive(1'b0, v, l, ($urandom_range(0, 3) != 0));
            model_step(ex, ey);
            sbq.push_back(ex);
            for (int b = 0; b < N; b++) if (ey[b]) mc[b]++;
            @(negedge clk); ex = sbq.pop_front(); checks++;
            if (obs !== ex) begin failures++; $display("FAIL random cyc=%0d got=%b exp=%b", k, obs, ex); end
            if (yumi_o != 0) begin
                j = 0;
                for (int b = 0; b < N; b++) if (yumi_o[b]) begin dc[b]++; j = b; end
                if (!$onehot(yumi_o)) ilv++;
                if (rem == 0) begin
                    for (int b = 0; b < N; b++) begin
                        if (b == j) wt[b] = 0;
                        else if (v_i[b]) wt[b]++;
                        else wt[b] = 0;
                        if (wt[b] > maxw) maxw = wt[b];
                    end
                    rem = int'(len_of(len_i, 3'(j))); src = j;
                end else begin
                    if (j != src) ilv++;
                    rem--;
                end
            end
        end
        for (int b = 0; b < N; b++) begin
            checks++;
            if (dc[b] != mc[b]) begin failures++; $display("FAIL random_count in=%0d got=%0d exp=%0d", b, dc[b], mc[b]); end
        end
        checks++;
        if (ilv != 0) begin failures++; $display("FAIL random_interleave got=%0d exp=0", ilv); end
        checks++;
        if (maxw > N - 1) begin failures++; $display("FAIL random_starve got=%0d exp<=%0d", maxw, N - 1); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_rotation();
        test_bubble();
        test_max_len_toggle();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
